rv_decode_stage: RTL and testbench

//  Registered RV32I/RV64I instruction-decode pipeline stage between fetch and register-read/execute.

---
 rtl/rv_isa_pkg.sv | 68 ++++++
 rtl/rv_imm_gen.sv | 34 +++
 rtl/rv_decode_stage.sv | 263 ++++++++++++++++++++++++++
 tb/tb_rv_decode_stage.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_isa_pkg.sv
// Shared RV32I/RV64I decode definitions: opcodes, ALU encodings, immediate
// formats, skid-stage states and the decoded bundle handed to execute.
package rv_isa_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_fmt_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_t;

    // Everything execute needs except the XLEN-wide pc/imm, which are kept
    // beside the bundle so the struct does not depend on XLEN.
    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [3:0] alu_action;
        logic [2:0] funct3;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       use_imm;
        logic       use_pc;
        logic       illegal;
    } dec_bundle_t;

    localparam int DEC_BUNDLE_W = $bits(dec_bundle_t);

    // Immediate layout implied by the major opcode; FMT_NONE for R-type and
    // unsupported opcodes so their immediate reads as zero.
    function automatic imm_fmt_t imm_fmt_of(input logic [6:0] opcode);
        imm_fmt_t fmt;
        case (opcode)
            OPC_OPIMM, OPC_LOAD, OPC_JALR: fmt = FMT_I;
            OPC_STORE:                     fmt = FMT_S;
            OPC_BRANCH:                    fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:            fmt = FMT_U;
            OPC_JAL:                       fmt = FMT_J;
            default:                       fmt = FMT_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational immediate generator: picks the format from the opcode and
// returns the immediate sign-extended from instr[31] to XLEN bits.
module rv_imm_gen
    import rv_isa_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_t        fmt
);

    logic signed [31:0] imm32;

    // Assemble the 32-bit immediate for the selected format.
    always_comb begin
        fmt   = imm_fmt_of(instr[6:0]);
        imm32 = '0;
        case (fmt)
            FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            FMT_U: imm32 = {instr[31:12], 12'b0};
            FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Signed cast widens to XLEN; U-type is sign-extended too on RV64.
    assign imm = XLEN'(imm32);

endmodule

// File: rtl/rv_decode_stage.sv
// Registered RV32I/RV64I decode stage with valid/ready handshake, optional
// 2-entry skid buffer and flush. Decoding happens before the registers, so
// both main and skid entries hold fully decoded bundles.
module rv_decode_stage
    import rv_isa_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [XLEN-1:0] imm,
    output logic [3:0]      alu_action,
    output logic [2:0]      funct3,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            branch,
    output logic            jump,
    output logic            use_imm,
    output logic            use_pc,
    output logic            illegal
);

    if (XLEN != 32 && XLEN != 64) begin : gen_bad_xlen
        $error("rv_decode_stage: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0] dec_imm;
    imm_fmt_t        dec_fmt;
    dec_bundle_t     dec_bundle;

    stage_state_t    state_reg, state_next;
    dec_bundle_t     main_bundle_reg;
    logic [XLEN-1:0] main_imm_reg, main_pc_reg;
    dec_bundle_t     skid_bundle;
    logic [XLEN-1:0] skid_imm, skid_pc;

    logic in_fire, out_fire;
    logic load_main, load_skid, main_from_skid;

    rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (in_instr),
        .imm   (dec_imm),
        .fmt   (dec_fmt)
    );

    // Opcode decode into register indices and control bits.
    always_comb begin
        dec_bundle = '0;
        case (in_instr[6:0])
            OPC_OP: begin
                dec_bundle.rd         = in_instr[11:7];
                dec_bundle.rs1        = in_instr[19:15];
                dec_bundle.rs2        = in_instr[24:20];
                dec_bundle.alu_action = {in_instr[30], in_instr[14:12]};
                dec_bundle.funct3     = in_instr[14:12];
                dec_bundle.reg_write  = 1'b1;
            end
            OPC_OPIMM: begin
                dec_bundle.rd         = in_instr[11:7];
                dec_bundle.rs1        = in_instr[19:15];
                // only the shift-right pair uses instr[30] (SRLI vs SRAI)
                dec_bundle.alu_action = {(in_instr[14:12] == 3'b101) ? in_instr[30] : 1'b0,
                                         in_instr[14:12]};
                dec_bundle.funct3     = in_instr[14:12];
                dec_bundle.reg_write  = 1'b1;
            end
            OPC_LOAD: begin
                dec_bundle.rd         = in_instr[11:7];
                dec_bundle.rs1        = in_instr[19:15];
                dec_bundle.alu_action = ALU_ADD;
                dec_bundle.funct3     = in_instr[14:12];
                dec_bundle.reg_write  = 1'b1;
                dec_bundle.mem_read   = 1'b1;
            end
            OPC_STORE: begin
                dec_bundle.rs1        = in_instr[19:15];
                dec_bundle.rs2        = in_instr[24:20];
                dec_bundle.alu_action = ALU_ADD;
                dec_bundle.funct3     = in_instr[14:12];
                dec_bundle.mem_write  = 1'b1;
            end
            OPC_BRANCH: begin
                dec_bundle.rs1        = in_instr[19:15];
                dec_bundle.rs2        = in_instr[24:20];
                dec_bundle.alu_action = ALU_SUB;
                dec_bundle.funct3     = in_instr[14:12];
                dec_bundle.branch     = 1'b1;
            end
            OPC_LUI: begin
                dec_bundle.rd         = in_instr[11:7];
                dec_bundle.alu_action = ALU_ADD;
                dec_bundle.reg_write  = 1'b1;
            end
            OPC_AUIPC: begin
                dec_bundle.rd         = in_instr[11:7];
                dec_bundle.alu_action = ALU_ADD;
                dec_bundle.reg_write  = 1'b1;
                dec_bundle.use_pc     = 1'b1;
            end
            OPC_JAL: begin
                dec_bundle.rd         = in_instr[11:7];
                dec_bundle.alu_action = ALU_ADD;
                dec_bundle.reg_write  = 1'b1;
                dec_bundle.jump       = 1'b1;
                dec_bundle.use_pc     = 1'b1;
            end
            OPC_JALR: begin
                dec_bundle.rd         = in_instr[11:7];
                dec_bundle.rs1        = in_instr[19:15];
                dec_bundle.alu_action = ALU_ADD;
                dec_bundle.funct3     = in_instr[14:12];
                dec_bundle.reg_write  = 1'b1;
                dec_bundle.jump       = 1'b1;
            end
            default: begin
                dec_bundle.illegal    = 1'b1;
            end
        endcase
        // every format except B feeds the immediate into the ALU
        dec_bundle.use_imm = (dec_fmt != FMT_NONE) && (dec_fmt != FMT_B);
    end

    assign out_valid = (state_reg != ST_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Occupancy FSM: next state plus load strobes for main/skid entries.
    always_comb begin
        state_next     = state_reg;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_reg)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_next = ST_ONE;
                    load_main  = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (in_fire && SKID_EN) begin
                    state_next = ST_TWO;
                    load_skid  = 1'b1;
                end else if (out_fire) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_fire) begin
                    state_next     = ST_ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
        // flush drops everything held and whatever is presented this cycle
        if (flush) begin
            state_next     = ST_EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Main output register: loads from decode, or from the skid entry on drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_bundle_reg <= '0;
            main_imm_reg    <= '0;
            main_pc_reg     <= '0;
        end else if (load_main) begin
            main_bundle_reg <= dec_bundle;
            main_imm_reg    <= dec_imm;
            main_pc_reg     <= in_pc;
        end else if (main_from_skid) begin
            main_bundle_reg <= skid_bundle;
            main_imm_reg    <= skid_imm;
            main_pc_reg     <= skid_pc;
        end
    end

    if (SKID_EN) begin : gen_skid
        dec_bundle_t     skid_bundle_reg;
        logic [XLEN-1:0] skid_imm_reg, skid_pc_reg;
        logic            in_ready_reg;

        // Skid entry captures the instruction accepted while output stalls.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                skid_bundle_reg <= '0;
                skid_imm_reg    <= '0;
                skid_pc_reg     <= '0;
            end else if (load_skid) begin
                skid_bundle_reg <= dec_bundle;
                skid_imm_reg    <= dec_imm;
                skid_pc_reg     <= in_pc;
            end
        end

        // in_ready is a flop so fetch never sees a path from out_ready.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                in_ready_reg <= 1'b1;
            end else begin
                in_ready_reg <= (state_next != ST_TWO);
            end
        end

        assign skid_bundle = skid_bundle_reg;
        assign skid_imm    = skid_imm_reg;
        assign skid_pc     = skid_pc_reg;
        assign in_ready    = in_ready_reg;
    end else begin : gen_no_skid
        logic unused_load_skid;

        assign skid_bundle      = '0;
        assign skid_imm         = '0;
        assign skid_pc          = '0;
        assign unused_load_skid = load_skid;
        assign in_ready         = ~out_valid | out_ready;
    end

    assign out_pc     = main_pc_reg;
    assign imm        = main_imm_reg;
    assign rd         = main_bundle_reg.rd;
    assign rs1        = main_bundle_reg.rs1;
    assign rs2        = main_bundle_reg.rs2;
    assign alu_action = main_bundle_reg.alu_action;
    assign funct3     = main_bundle_reg.funct3;
    assign reg_write  = main_bundle_reg.reg_write;
    assign mem_read   = main_bundle_reg.mem_read;
    assign mem_write  = main_bundle_reg.mem_write;
    assign branch     = main_bundle_reg.branch;
    assign jump       = main_bundle_reg.jump;
    assign use_imm    = main_bundle_reg.use_imm;
    assign use_pc     = main_bundle_reg.use_pc;
    assign illegal    = main_bundle_reg.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: instance a is XLEN=32 with skid buffer, instance
// b is XLEN=64 without. Both share the stimulus; a queue model per instance
// tracks what each must present.
module tb_rv_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    always #5 clk = ~clk;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_pc, a_imm;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [3:0]  a_alu;
    logic [2:0]  a_funct3;
    logic        a_reg_write, a_mem_read, a_mem_write, a_branch, a_jump, a_use_imm, a_use_pc, a_illegal;

    logic        b_in_ready, b_out_valid;
    logic [63:0] b_pc, b_imm;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [3:0]  b_alu;
    logic [2:0]  b_funct3;
    logic        b_reg_write, b_mem_read, b_mem_write, b_branch, b_jump, b_use_imm, b_use_pc, b_illegal;

    logic [29:0] a_ctrl, b_ctrl;
    assign a_ctrl = {a_rd, a_rs1, a_rs2, a_alu, a_funct3, a_reg_write, a_mem_read, a_mem_write,
                     a_branch, a_jump, a_use_imm, a_use_pc, a_illegal};
    assign b_ctrl = {b_rd, b_rs1, b_rs2, b_alu, b_funct3, b_reg_write, b_mem_read, b_mem_write,
                     b_branch, b_jump, b_use_imm, b_use_pc, b_illegal};

    rv_decode_stage #(.XLEN(32), .SKID_EN(1'b1)) u_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_pc), .rd(a_rd), .rs1(a_rs1), .rs2(a_rs2), .imm(a_imm), .alu_action(a_alu),
        .funct3(a_funct3), .reg_write(a_reg_write), .mem_read(a_mem_read), .mem_write(a_mem_write),
        .branch(a_branch), .jump(a_jump), .use_imm(a_use_imm), .use_pc(a_use_pc), .illegal(a_illegal)
    );

    rv_decode_stage #(.XLEN(64), .SKID_EN(1'b0)) u_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pc(b_pc), .rd(b_rd), .rs1(b_rs1), .rs2(b_rs2), .imm(b_imm), .alu_action(b_alu),
        .funct3(b_funct3), .reg_write(b_reg_write), .mem_read(b_mem_read), .mem_write(b_mem_write),
        .branch(b_branch), .jump(b_jump), .use_imm(b_use_imm), .use_pc(b_use_pc), .illegal(b_illegal)
    );

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } item_t;
    item_t qa[$];
    item_t qb[$];

    // Reference decode of control fields, straight from the opcode table.
    function automatic logic [29:0] exp_ctrl(input logic [31:0] w);
        logic [4:0] rd_e, rs1_e, rs2_e;
        logic [3:0] alu_e;
        logic [2:0] f3_e;
        logic rw, mr, mw, br, jp, ui, up, il;
        rd_e = 0; rs1_e = 0; rs2_e = 0; alu_e = 0; f3_e = 0;
        rw = 0; mr = 0; mw = 0; br = 0; jp = 0; ui = 0; up = 0; il = 0;
        case (w[6:0])
            7'h33: begin rd_e = w[11:7]; rs1_e = w[19:15]; rs2_e = w[24:20];
                         alu_e = {w[30], w[14:12]}; f3_e = w[14:12]; rw = 1; end
            7'h13: begin rd_e = w[11:7]; rs1_e = w[19:15];
                         alu_e = {(w[14:12] == 3'd5) ? w[30] : 1'b0, w[14:12]};
                         f3_e = w[14:12]; rw = 1; ui = 1; end
            7'h03: begin rd_e = w[11:7]; rs1_e = w[19:15]; f3_e = w[14:12]; rw = 1; mr = 1; ui = 1; end
            7'h23: begin rs1_e = w[19:15]; rs2_e = w[24:20]; f3_e = w[14:12]; mw = 1; ui = 1; end
            7'h63: begin rs1_e = w[19:15]; rs2_e = w[24:20]; alu_e = 4'd8; f3_e = w[14:12]; br = 1; end
            7'h37: begin rd_e = w[11:7]; rw = 1; ui = 1; end
            7'h17: begin rd_e = w[11:7]; rw = 1; ui = 1; up = 1; end
            7'h6F: begin rd_e = w[11:7]; rw = 1; jp = 1; ui = 1; up = 1; end
            7'h67: begin rd_e = w[11:7]; rs1_e = w[19:15]; f3_e = w[14:12]; rw = 1; jp = 1; ui = 1; end
            default: il = 1;
        endcase
        return {rd_e, rs1_e, rs2_e, alu_e, f3_e, rw, mr, mw, br, jp, ui, up, il};
    endfunction

    // Reference immediate as a signed 64-bit integer.
    function automatic logic [63:0] exp_imm(input logic [31:0] w);
        longint v;
        v = 0;
        case (w[6:0])
            7'h13, 7'h03, 7'h67: v = longint'($signed(w[31:20]));
            7'h23: v = longint'($signed({w[31:25], w[11:7]}));
            7'h63: v = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
            7'h37, 7'h17: v = longint'($signed({w[31:12], 12'h000}));
            7'h6F: v = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
            default: v = 0;
        endcase
        return v;
    endfunction

    // Advance the queue models by one edge using the inputs about to be sampled.
    task automatic model_step();
        bit ra, rb;
        if (!rst) begin
            ra = (qa.size() < 2);
            rb = (qb.size() == 0) || out_ready;
            if (flush) begin
                qa.delete();
                qb.delete();
            end else begin
                if (out_ready && qa.size() > 0) void'(qa.pop_front());
                if (in_valid && ra) qa.push_back('{in_instr, in_pc});
                if (out_ready && qb.size() > 0) void'(qb.pop_front());
                if (in_valid && rb) qb.push_back('{in_instr, in_pc});
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] w, input logic [63:0] pc,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_instr  = w;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic test_reset();
        drive(1, 32'h00C58533, 64'h40, 0, 0);
        tick();
        drive(1, 32'hFFF50513, 64'h44, 0, 0);
        tick();
        vectors++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got=%b exp=1", a_out_valid); end
        #2 rst = 1'b1;
        #1;
        vectors++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_a_valid got=%b exp=0", a_out_valid); end
        vectors++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_a_ready got=%b exp=1", a_in_ready); end
        vectors++; if ({a_ctrl, a_imm, a_pc} !== 94'd0) begin errors++; $display("FAIL rst_a_outputs got=%h exp=0", {a_ctrl, a_imm, a_pc}); end
        vectors++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin errors++; $display("FAIL rst_b_hs got=%b%b exp=01", b_out_valid, b_in_ready); end
        vectors++; if ({b_ctrl, b_imm, b_pc} !== 158'd0) begin errors++; $display("FAIL rst_b_outputs got=%h exp=0", {b_ctrl, b_imm, b_pc}); end
        qa.delete();
        qb.delete();
        drive(0, 0, 0, 1, 0);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add_addi();
        drive(1, 32'h00C58533, 64'h1000, 1, 0);
        tick();
        vectors++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", a_out_valid); end
        vectors++; if ({a_rd, a_rs1, a_rs2} !== {5'd10, 5'd11, 5'd12}) begin errors++; $display("FAIL add_regs got=%0d,%0d,%0d exp=10,11,12", a_rd, a_rs1, a_rs2); end
        vectors++; if (a_alu !== 4'b0000 || a_reg_write !== 1'b1) begin errors++; $display("FAIL add_alu got=%b/%b exp=0000/1", a_alu, a_reg_write); end
        drive(1, 32'hFFF50513, 64'h1004, 1, 0);
        tick();
        vectors++; if (a_imm !== 32'hFFFFFFFF || a_use_imm !== 1'b1) begin errors++; $display("FAIL addi_imm got=%h/%b exp=ffffffff/1", a_imm, a_use_imm); end
        vectors++; if (b_imm !== 64'hFFFFFFFF_FFFFFFFF) begin errors++; $display("FAIL addi_imm64 got=%h exp=ffffffffffffffff", b_imm); end
        vectors++; if (a_pc !== 32'h1004) begin errors++; $display("FAIL addi_pc got=%h exp=1004", a_pc); end
        drive(0, 0, 0, 1, 0);
        tick();
    endtask

    task automatic test_xlen64();
        drive(1, 32'hFE000EE3, 64'h2000, 1, 0);
        tick();
        vectors++; if (b_imm !== 64'hFFFFFFFF_FFFFFFFC) begin errors++; $display("FAIL beq_imm got=%h exp=fffffffffffffffc", b_imm); end
        vectors++; if (b_branch !== 1'b1 || b_alu !== 4'b1000) begin errors++; $display("FAIL beq_ctrl got=%b/%b exp=1/1000", b_branch, b_alu); end
        vectors++; if (a_imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL beq_imm32 got=%h exp=fffffffc", a_imm); end
        drive(1, 32'h800000B7, 64'h2004, 1, 0);
        tick();
        vectors++; if (b_imm !== 64'hFFFFFFFF_80000000) begin errors++; $display("FAIL lui_imm got=%h exp=ffffffff80000000", b_imm); end
        vectors++; if (b_rs1 !== 5'd0 || b_rd !== 5'd1) begin errors++; $display("FAIL lui_regs got=%0d/%0d exp=0/1", b_rs1, b_rd); end
        drive(0, 0, 0, 1, 0);
        tick();
    endtask

    task automatic test_backpressure();
        drive(1, 32'h00100093, 64'h100, 0, 0);
        tick();
        drive(1, 32'h00200113, 64'h104, 0, 0);
        tick();
        vectors++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got=%b exp=0", a_in_ready); end
        drive(1, 32'h00300193, 64'h108, 0, 0);
        tick();
        vectors++; if (a_in_ready !== 1'b0 || a_pc !== 32'h100) begin errors++; $display("FAIL bp_hold got=%b/%h exp=0/100", a_in_ready, a_pc); end
        drive(0, 0, 0, 1, 0);
        tick();
        vectors++; if (a_out_valid !== 1'b1 || a_pc !== 32'h104) begin errors++; $display("FAIL bp_second got=%b/%h exp=1/104", a_out_valid, a_pc); end
        tick();
        vectors++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got=%b exp=0", a_out_valid); end
    endtask

    task automatic test_flush();
        drive(1, 32'h00100093, 64'h200, 0, 0);
        tick();
        drive(1, 32'h00200113, 64'h204, 0, 0);
        tick();
        drive(1, 32'h00300193, 64'h208, 0, 1);
        tick();
        vectors++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL flush_empty got=%b/%b exp=0/1", a_out_valid, a_in_ready); end
        drive(1, 32'h00400213, 64'h20C, 1, 0);
        tick();
        vectors++; if (a_out_valid !== 1'b1 || a_pc !== 32'h20C) begin errors++; $display("FAIL flush_next got=%b/%h exp=1/20c", a_out_valid, a_pc); end
        drive(0, 0, 0, 1, 0);
        tick();
    endtask

    task automatic test_illegal();
        logic [31:0] words [2];
        words[0] = 32'h0000007F;
        words[1] = 32'h00000000;
        for (int i = 0; i < 2; i++) begin
            drive(1, words[i], 64'h300 + 64'(4 * i), 1, 0);
            tick();
            vectors++; if (a_out_valid !== 1'b1 || a_illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag[%0d] got=%b/%b exp=1/1", i, a_out_valid, a_illegal); end
            vectors++; if (a_ctrl !== 30'd1 || a_imm !== 32'd0) begin errors++; $display("FAIL illegal_fields[%0d] got=%h/%h exp=1/0", i, a_ctrl, a_imm); end
        end
        drive(0, 0, 0, 1, 0);
        tick();
    endtask

    task automatic test_random();
        logic [6:0]  opc [9];
        logic [31:0] w;
        logic [63:0] ei;
        logic [29:0] ec;
        opc = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
        for (int n = 0; n < 2000; n++) begin
            vectors++; if (a_out_valid !== (qa.size() > 0) || a_in_ready !== (qa.size() < 2)) begin
                errors++; $display("FAIL rnd_a_hs[%0d] got=%b%b exp=%b%b", n, a_out_valid, a_in_ready, qa.size() > 0, qa.size() < 2); end
            if (qa.size() > 0) begin
                ec = exp_ctrl(qa[0].instr); ei = exp_imm(qa[0].instr);
                vectors++; if ({a_ctrl, a_imm, a_pc} !== {ec, ei[31:0], qa[0].pc[31:0]}) begin
                    errors++; $display("FAIL rnd_a_bundle[%0d] got=%h exp=%h", n, {a_ctrl, a_imm, a_pc}, {ec, ei[31:0], qa[0].pc[31:0]}); end
            end
            vectors++; if (b_out_valid !== (qb.size() > 0) || b_in_ready !== (qb.size() == 0 || out_ready)) begin
                errors++; $display("FAIL rnd_b_hs[%0d] got=%b%b exp=%b%b", n, b_out_valid, b_in_ready, qb.size() > 0, qb.size() == 0 || out_ready); end
            if (qb.size() > 0) begin
                ec = exp_ctrl(qb[0].instr); ei = exp_imm(qb[0].instr);
                vectors++; if ({b_ctrl, b_imm, b_pc} !== {ec, ei, qb[0].pc}) begin
                    errors++; $display("FAIL rnd_b_bundle[%0d] got=%h exp=%h", n, {b_ctrl, b_imm, b_pc}, {ec, ei, qb[0].pc}); end
            end
            w = $urandom;
            if ($urandom_range(0, 9) < 8) w[6:0] = opc[$urandom_range(0, 8)];
            drive($urandom_range(0, 9) < 7, w, {$urandom, $urandom},
                  $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
            tick();
        end
        drive(0, 0, 0, 1, 0);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 1, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_add_addi();
        test_xlen64();
        test_backpressure();
        test_flush();
        test_illegal();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
